// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter and its picker.
package rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic int ID_W(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_pick
   import rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 8
) (
   input  logic [NUM_REQ-1:0]          req,
   input  logic [ID_W(NUM_REQ)-1:0]    ptr,
   output logic [NUM_REQ-1:0]          pick,
   output logic [ID_W(NUM_REQ)-1:0]    pick_id,
   output logic                        any
);

   localparam int IW = ID_W(NUM_REQ);

   logic [NUM_REQ-1:0]   req_hi;
   logic [2*NUM_REQ-1:0] dbl;

   // Lower half keeps only bits at or above ptr; upper half is the wrapped copy.
   always_comb begin
      req_hi = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_hi[i] = req[i] && (i >= int'(ptr));
      end
      dbl = {req, req_hi};
   end

   always_comb begin
      pick    = '0;
      pick_id = '0;
      any     = 1'b0;
      for (int i = 0; i < 2 * NUM_REQ; i++) begin
         if (!any && dbl[i]) begin
            any                 = 1'b1;
            pick[i % NUM_REQ]   = 1'b1;
            pick_id             = IW'(i % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, valid/ready handshake
// and a wrapping accept counter.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       gnt_ready,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       gnt_valid,
   output logic [ID_W(NUM_REQ)-1:0]   gnt_id,
   output logic [CNT_WIDTH-1:0]       accept_cnt,
   output arb_state_e                 dbg_state
);

   localparam int IW = ID_W(NUM_REQ);

   // Handshake: a grant is accepted on a rising edge where gnt_valid and
   // gnt_ready are both high; gnt/gnt_id are held stable until then.
   arb_state_e           state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]        gnt_id_q, gnt_id_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic                 accept;
   logic [IW-1:0]        ptr_next;
   logic [IW-1:0]        search_ptr;
   logic [NUM_REQ-1:0]   pick;
   logic [IW-1:0]        pick_id;
   logic                 any;

   assign accept     = (state_q == GRANT) && gnt_ready;
   assign ptr_next   = (gnt_id_q == IW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IW'(1);
   // On accept the search already uses the rotated pointer, so no bubble.
   assign search_ptr = accept ? ptr_next : ptr_q;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req     (req),
      .ptr     (search_ptr),
      .pick    (pick),
      .pick_id (pick_id),
      .any     (any)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (any) begin
               gnt_d    = pick;
               gnt_id_d = pick_id;
               state_d  = GRANT;
            end
         end
         GRANT: begin
            if (gnt_ready) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
               ptr_d = ptr_next;
               if (any) begin
                  gnt_d    = pick;
                  gnt_id_d = pick_id;
               end else begin
                  gnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         cnt_q    <= cnt_d;
      end
   end

   assign gnt        = gnt_q;
   assign gnt_valid  = (state_q == GRANT);
   assign gnt_id     = gnt_id_q;
   assign accept_cnt = cnt_q;
   assign dbg_state  = state_q;

endmodule
